// File: rtl/cpu_defs.sv
// Shared pipeline definitions for the 5-stage core: Tuse/Tnew encodings,
// multiply/divide latencies and the sequencer state type.
package cpu_defs;

    localparam logic [3:0] TUSE_D = 4'd0;
    localparam logic [3:0] TUSE_E = 4'd1;
    localparam logic [3:0] TUSE_M = 4'd2;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A producer blocks a consumer when its result arrives later than the
    // consumer needs it. A stage that does not write, or a match on $0,
    // never blocks.
    function automatic logic tnew_blocks(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       reg_write,
        input logic [3:0] tnew,
        input logic [3:0] tuse
    );
        return (src == dst) && reg_write && (tnew > tuse) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/md_seq_counter.sv
// Multiply/divide unit sequencer: loads the operation latency on a start
// pulse and counts down to zero; busy is registered alongside the count.
//
//   state   | meaning
//   --------+------------------------------------------------
//   MD_IDLE | count is 0, unit free, waiting for a start
//   MD_BUSY | count is nonzero, decrements once per cycle
module md_seq_counter
    import cpu_defs::*;
#(
    parameter int CNT_W    = 4,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    cnt_d   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = MD_IDLE;
            end
        endcase
        busy_d = (cnt_d != '0);
    end

    // Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = busy_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: Tnew/Tuse RAW stalls, MDU occupancy stalls,
// and the MDU start pulse. Drives PC/F-D enables and the D/E bubble.
module hazard_stall_ctrl
    import cpu_defs::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    input  logic             D_A1use,
    input  logic             D_A2use,
    input  logic [3:0]       D_Tuse_rs,
    input  logic [3:0]       D_Tuse_rt,
    input  logic             D_MD_op,
    input  logic [4:0]       E_A3,
    input  logic             E_RegWrite,
    input  logic [3:0]       E_Tnew,
    input  logic [4:0]       M_A3,
    input  logic             M_RegWrite,
    input  logic [3:0]       M_Tnew,
    input  logic             E_MD_mult,
    input  logic             E_MD_div,
    input  logic             Req,
    output logic             stall,
    output logic             PC_en,
    output logic             FD_en,
    output logic             DE_clr,
    output logic             E_MD_start,
    output logic             MD_busy,
    output logic [CNT_W-1:0] MD_cnt
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic md_start;
    logic md_busy;

    always_comb begin
        stall_rs = D_A1use &&
                   (tnew_blocks(D_A1, E_A3, E_RegWrite, E_Tnew, D_Tuse_rs) ||
                    tnew_blocks(D_A1, M_A3, M_RegWrite, M_Tnew, D_Tuse_rs));
        stall_rt = D_A2use &&
                   (tnew_blocks(D_A2, E_A3, E_RegWrite, E_Tnew, D_Tuse_rt) ||
                    tnew_blocks(D_A2, M_A3, M_RegWrite, M_Tnew, D_Tuse_rt));
    end

    // A flushed instruction must not launch the MDU; an op in flight is left
    // to finish even if Req arrives later.
    assign md_start = (E_MD_mult || E_MD_div) && !Req && !md_busy;
    assign stall_md = D_MD_op && (md_busy || md_start);

    assign stall      = stall_rs || stall_rt || stall_md;
    assign PC_en      = !stall;
    assign FD_en      = !stall;
    assign DE_clr     = stall;
    assign E_MD_start = md_start;
    assign MD_busy    = md_busy;

    // If both op flags are ever seen together, the divide latency is used.
    md_seq_counter #(
        .CNT_W    (CNT_W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_seq (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (E_MD_div),
        .cnt    (MD_cnt),
        .busy   (md_busy)
    );

    a_md_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(E_MD_mult && E_MD_div));

    a_md_no_overlap: assert property (@(posedge clk) disable iff (reset)
        !((E_MD_mult || E_MD_div) && md_busy));

endmodule
